instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 40 ++++
 rtl/instr_fetch.sv | 77 +++++++
 tb/tb_instr_fetch.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: program-counter side, program-memory side and
// decoder side of the instruction fetch buffer.
//   slave  : the fetch unit (instr_fetch)
//   master : the environment (PC, program memory, decoder)
// Signals:
//   pc_addr     current program counter
//   pc_advance  PC increment enable, high in each issue cycle
//   mem_req     program memory read strobe
//   mem_addr    program memory address (follows pc_addr)
//   mem_rdata   read data, valid one cycle after mem_req
//   flush       taken branch, discards fetched and in-flight words
//   instr       head instruction
//   instr_addr  address the head instruction came from
//   instr_valid head entry valid
//   instr_ready decoder accepts the head entry
interface instr_fetch_if #(
  parameter int AddrSz  = 6,
  parameter int InstrSz = 16
);
  logic [AddrSz-1:0]  pc_addr;
  logic               pc_advance;
  logic               mem_req;
  logic [AddrSz-1:0]  mem_addr;
  logic [InstrSz-1:0] mem_rdata;
  logic               flush;
  logic [InstrSz-1:0] instr;
  logic [AddrSz-1:0]  instr_addr;
  logic               instr_valid;
  logic               instr_ready;

  modport slave (
    input  pc_addr, mem_rdata, flush, instr_ready,
    output pc_advance, mem_req, mem_addr, instr, instr_addr, instr_valid
  );

  modport master (
    output pc_addr, mem_rdata, flush, instr_ready,
    input  pc_advance, mem_req, mem_addr, instr, instr_addr, instr_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch buffer: issues reads to a 1-cycle-latency program
// memory, collects returned words with their addresses in a 2-entry FIFO
// and hands them to the decoder with a valid/ready handshake.
// Ports:
//   clk      clock, all state on rising edge
//   n_reset  synchronous active-low reset
//   bus      instr_fetch_if.slave (PC, memory and decoder signals)
module instr_fetch #(
  parameter int AddrSz  = 6,
  parameter int InstrSz = 16
) (
  input  logic          clk,
  input  logic          n_reset,
  instr_fetch_if.slave  bus
);

  typedef struct packed {
    logic [AddrSz-1:0]  addr;
    logic [InstrSz-1:0] data;
  } entry_t;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  entry_t [1:0]      fifo_q, fifo_d;
  logic [1:0]        count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [AddrSz-1:0] inflight_addr_q, inflight_addr_d;

  logic       pop, push, issue;
  logic [1:0] after_pop;
  logic [2:0] occ;

  assign pop  = (count_q != 2'd0) && bus.instr_ready;
  assign push = inflight_q && !bus.flush;

  // Credit: slots already committed after this cycle's pop. Issuing only
  // while this is below 2 means a returning word always finds room.
  assign occ   = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = n_reset && !bus.flush && (occ < 3'd2);

  assign bus.mem_req     = issue;
  assign bus.pc_advance  = issue;
  assign bus.mem_addr    = bus.pc_addr;
  assign bus.instr_valid = (count_q != 2'd0);
  assign bus.instr       = fifo_q[0].data;
  assign bus.instr_addr  = fifo_q[0].addr;

  always_comb begin
    fifo_d          = fifo_q;
    after_pop       = count_q - {1'b0, pop};
    count_d         = after_pop;
    inflight_d      = issue;
    inflight_addr_d = issue ? bus.pc_addr : inflight_addr_q;
    if (pop) fifo_d[0] = fifo_q[1];
    // Push lands right behind whatever survives the pop (slot 0 or 1).
    if (push) begin
      fifo_d[after_pop[0]] = entry_t'{addr: inflight_addr_q, data: bus.mem_rdata};
      count_d              = after_pop + 2'd1;
    end
    // Flush drops everything; stale contents stay but are never valid.
    if (bus.flush) count_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      fifo_q          <= '0;
      count_q         <= 2'd0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      fifo_q          <= fifo_d;
      count_q         <= count_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC and 1-cycle program memory models, directed
// scenarios (reset, streaming, backpressure, flush, wrap, mid-run reset)
// followed by random ready/flush/reset traffic. Expected delivery stream
// is the consecutive address sequence from the last reset/flush target.
module tb_instr_fetch;
  localparam int AW = 6;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if #(.AddrSz(AW), .InstrSz(IW)) bus();
  instr_fetch #(.AddrSz(AW), .InstrSz(IW)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus)
  );

  logic [AW-1:0] pc, tgt = '0;
  logic flush = 1'b0, ready = 1'b0;
  assign bus.pc_addr     = pc;
  assign bus.flush       = flush;
  assign bus.instr_ready = ready;

  function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
    return IW'(16'hA000 + {10'b0, a});
  endfunction

  // Program memory: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk)
    bus.mem_rdata <= bus.mem_req ? word(bus.mem_addr) : IW'($urandom);

  // Program counter: reset to 0, branch redirect on flush, else advance.
  always @(posedge clk)
    if (!n_reset)            pc <= '0;
    else if (flush)          pc <= tgt;
    else if (bus.pc_advance) pc <= pc + 1'b1;

  typedef struct { logic [AW-1:0] a; logic [IW-1:0] d; } exp_t;
  exp_t exp_q[$];
  logic [AW-1:0] nxt;
  int total = 0, bad = 0, xfers = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{a: nxt, d: word(nxt)});
      nxt = nxt + 1'b1;
    end
  endtask

  task automatic restart(input logic [AW-1:0] a);
    exp_q.delete();
    nxt = a;
    refill();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      refill();
    end
  endtask

  // Scoreboard monitor: every transfer must match the expected stream head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (n_reset === 1'b1 && bus.instr_valid === 1'b1 && ready === 1'b1) begin
      xfers++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty addr=%0d t=%0t", bus.instr_addr, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_addr", 32'(bus.instr_addr), 32'(e.a));
        chk("sb_data", 32'(bus.instr), 32'(e.d));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  int nreq, k, r, x0;

  initial begin
    restart('0);
    // Reset and streaming
    ready = 1'b1; n_reset = 1'b0;
    step(1);
    @(negedge clk);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_pc_adv", 32'(bus.pc_advance), 0);
    step(1);
    n_reset = 1'b1; restart('0);
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.instr_valid), 0);
    chk("post_rst_instr", 32'(bus.instr), 0);
    chk("post_rst_addr", 32'(bus.instr_addr), 0);
    chk("first_issue", 32'(bus.mem_req), 1);
    chk("first_mem_addr", 32'(bus.mem_addr), 0);
    step(1);
    @(negedge clk);
    chk("lat_valid_early", 32'(bus.instr_valid), 0);
    step(1);
    @(negedge clk);
    chk("lat_valid", 32'(bus.instr_valid), 1);
    chk("lat_instr", 32'(bus.instr), 32'h0000A000);
    chk("lat_addr", 32'(bus.instr_addr), 0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      @(negedge clk);
      chk("stream_gap", 32'(bus.instr_valid), 1);
    end

    // Backpressure from reset
    ready = 1'b0; n_reset = 1'b0;
    step(1);
    n_reset = 1'b1; restart('0);
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.mem_req) nreq++;
      if (i >= 2) begin
        chk("bp_valid", 32'(bus.instr_valid), 1);
        chk("bp_head", 32'(bus.instr_addr), 0);
      end
      step(1);
    end
    chk("bp_req_count", 32'(nreq), 2);
    ready = 1'b1;
    @(negedge clk);
    chk("bp_resume", 32'(bus.mem_req), 1);
    step(6);

    // Flush while an entry is in flight
    n_reset = 1'b0;
    step(1);
    n_reset = 1'b1; restart('0);
    k = 0;
    while (pc != 6 && k < 20) begin step(1); k++; end
    chk("flush_reach_pc6", 32'(pc), 6);
    flush = 1'b1; tgt = 6'd20;
    @(negedge clk);
    chk("flush_no_req", 32'(bus.mem_req), 0);
    chk("flush_no_adv", 32'(bus.pc_advance), 0);
    step(1);
    flush = 1'b0; restart(6'd20);
    @(negedge clk);
    chk("flush_empty", 32'(bus.instr_valid), 0);
    chk("flush_resume_req", 32'(bus.mem_req), 1);
    chk("flush_resume_addr", 32'(bus.mem_addr), 20);
    step(2);
    @(negedge clk);
    chk("flush_new_valid", 32'(bus.instr_valid), 1);
    chk("flush_new_addr", 32'(bus.instr_addr), 20);
    step(4);

    // Wrap-around 62,63,0,1
    flush = 1'b1; tgt = 6'd62;
    step(1);
    flush = 1'b0; restart(6'd62);
    x0 = xfers;
    step(8);
    chk("wrap_progress", 32'(xfers - x0 >= 5), 1);

    // Mid-run reset with a word in flight
    n_reset = 1'b0;
    @(negedge clk);
    chk("midrst_req", 32'(bus.mem_req), 0);
    chk("midrst_adv", 32'(bus.pc_advance), 0);
    step(1);
    n_reset = 1'b1; restart('0);
    @(negedge clk);
    chk("midrst_valid", 32'(bus.instr_valid), 0);
    chk("midrst_instr", 32'(bus.instr), 0);
    step(1);
    @(negedge clk);
    chk("midrst_no_stale", 32'(bus.instr_valid), 0);
    step(1);
    @(negedge clk);
    chk("midrst_valid2", 32'(bus.instr_valid), 1);
    chk("midrst_a000", 32'(bus.instr), 32'h0000A000);
    step(2);

    // Random traffic
    x0 = xfers;
    for (int i = 0; i < 1500; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (r < 3) begin
        flush = 1'b1; tgt = AW'($urandom);
        @(negedge clk);
        chk("rand_flush_no_req", 32'(bus.mem_req), 0);
        step(1);
        flush = 1'b0; restart(tgt);
      end else if (r == 3) begin
        n_reset = 1'b0;
        @(negedge clk);
        chk("rand_rst_no_req", 32'(bus.mem_req), 0);
        step(1);
        n_reset = 1'b1; restart('0);
      end else begin
        step(1);
      end
    end
    chk("rand_progress", 32'(xfers - x0 > 300), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
